// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
//
// Shared constants and types for the register-file writeback arbiter.
//   RegAddrBits / DataBusBits : register address and data widths
//   RegZero / DataZero        : reset values; RegZero is the hardwired x0
//   WbStateNormal/WbStateBoost: priority FSM encodings
//   wb_state_t                : priority FSM state type (also the debug view)
//   wb_req_t                  : one writeback request (destination + data)
//   wb_writes_reg()           : true when a destination really writes the file
// -----------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

  localparam int RegAddrBits = 5;
  localparam int DataBusBits = 32;
  localparam int NumRegs     = 1 << RegAddrBits;

  localparam logic [RegAddrBits-1:0] RegZero  = '0;
  localparam logic [DataBusBits-1:0] DataZero = '0;

  // Width of the memory starvation counter; STARVE_LIMIT must fit in it.
  localparam int StarveBits = 4;

  localparam logic WbStateNormal = 1'b0;
  localparam logic WbStateBoost  = 1'b1;

  typedef enum logic {
    WB_NORMAL = WbStateNormal,  // ALU has priority
    WB_BOOST  = WbStateBoost    // memory has priority after starving
  } wb_state_t;

  typedef struct packed {
    logic [RegAddrBits-1:0] rd;
    logic [DataBusBits-1:0] data;
  } wb_req_t;

  // x0 is hardwired: writes to it are accepted but never reach the file.
  function automatic logic wb_writes_reg(input logic [RegAddrBits-1:0] rd);
    return rd != RegZero;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard
//
// Busy vector of destination registers that have an outstanding load.
//   clk, reset          : clock, asynchronous active-low reset
//   issue_valid/rd      : a load is issued -> mark rd busy
//   clr_valid/rd        : a load writes back -> clear rd
//   query_rs1/rs2       : source registers to look up
//   rs1_busy/rs2_busy   : lookup results, from registered state only
//
// When a set and a clear hit the same register in one cycle the set wins:
// the new load is still outstanding after the old one retires. x0 is never
// marked busy.
// -----------------------------------------------------------------------------
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [RegAddrBits-1:0] issue_rd,
  input  logic                   clr_valid,
  input  logic [RegAddrBits-1:0] clr_rd,
  input  logic [RegAddrBits-1:0] query_rs1,
  input  logic [RegAddrBits-1:0] query_rs2,
  output logic                   rs1_busy,
  output logic                   rs2_busy
);

  logic [NumRegs-1:0] busy_q;
  logic [NumRegs-1:0] busy_d;
  logic [NumRegs-1:0] set_mask;
  logic [NumRegs-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && wb_writes_reg(issue_rd)) set_mask[issue_rd] = 1'b1;
    if (clr_valid) clr_mask[clr_rd] = 1'b1;
    // Clear first, then set, so a same-cycle collision leaves the bit set.
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // No bypass: an issue in this cycle is visible to queries next cycle.
  assign rs1_busy = busy_q[query_rs1];
  assign rs2_busy = busy_q[query_rs2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port between the ALU writeback path
// and the variable-latency load unit. The ALU normally wins; a starvation
// counter forces memory to win after STARVE_LIMIT consecutive denied cycles.
// The winner is registered onto rf_we / rf_wr_addr / rf_wr_data, which the
// register file commits on the following falling edge.
//
// Parameters
//   STARVE_LIMIT : denied cycles before memory is boosted (legal 1..15)
// Ports
//   clk, reset                    : clock, asynchronous active-low reset
//   alu_valid/ready/rd/data       : ALU writeback request
//   mem_valid/ready/rd/data       : load writeback request
//   rf_we, rf_wr_addr, rf_wr_data : registered register-file write port
//   issue_valid, issue_rd,
//   query_rs1/2, rs1/2_busy       : load scoreboard (WB_SCOREBOARD_EN only)
//   dbg_state                     : current priority FSM state
//
// Build option: define WB_SCOREBOARD_EN to build the outstanding-load
// scoreboard and its ports. Without it arbitration is unchanged.
//
// Handshake: a transfer happens when valid && ready at a rising clock edge.
// A requester keeps valid, rd and data stable until it sees ready. ready is
// combinational from the FSM state and the valids, at most one ready is high
// per cycle, and both readies are low while reset is asserted.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [RegAddrBits-1:0] alu_rd,
  input  logic [DataBusBits-1:0] alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [RegAddrBits-1:0] mem_rd,
  input  logic [DataBusBits-1:0] mem_data,
  output logic                   rf_we,
  output logic [RegAddrBits-1:0] rf_wr_addr,
  output logic [DataBusBits-1:0] rf_wr_data,
`ifdef WB_SCOREBOARD_EN
  input  logic                   issue_valid,
  input  logic [RegAddrBits-1:0] issue_rd,
  input  logic [RegAddrBits-1:0] query_rs1,
  input  logic [RegAddrBits-1:0] query_rs2,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
`endif
  output wb_state_t              dbg_state
);

  localparam logic [StarveBits-1:0] StarveLimitW = StarveBits'(STARVE_LIMIT);
  localparam logic [StarveBits-1:0] StarveMax    = '1;

  wb_state_t             state_q;
  wb_state_t             state_d;
  logic [StarveBits-1:0] starve_q;
  logic [StarveBits-1:0] starve_d;
  logic                  alu_win;
  logic                  mem_win;
  logic                  alu_xfer;
  logic                  mem_xfer;
  wb_req_t               win_req;

  // ---------------------------------------------------------------------------
  // FSM output logic: who owns the write port this cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_win = 1'b0;
    mem_win = 1'b0;
    if (state_q == WB_BOOST) begin
      if (mem_valid)      mem_win = 1'b1;
      else if (alu_valid) alu_win = 1'b1;
    end else begin
      if (alu_valid)      alu_win = 1'b1;
      else if (mem_valid) mem_win = 1'b1;
    end
  end

  // Gating with reset keeps both readies low during reset even though the
  // state register already reads NORMAL.
  assign alu_ready = alu_win & reset;
  assign mem_ready = mem_win & reset;
  assign alu_xfer  = alu_ready;  // alu_win implies alu_valid
  assign mem_xfer  = mem_ready;  // mem_win implies mem_valid

  // ---------------------------------------------------------------------------
  // Starvation counter: consecutive cycles memory asked and was refused.
  // Saturates so an out-of-range limit cannot wrap it back to zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_d = starve_q;
    if (!mem_valid || mem_xfer) starve_d = '0;
    else if (starve_q != StarveMax) starve_d = starve_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic.
  // The boost is taken on the edge where the counter reaches the limit, so
  // under continuous ALU traffic memory wins on its (STARVE_LIMIT+1)th cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_NORMAL: begin
        if (mem_valid && !mem_xfer && (starve_d >= StarveLimitW)) state_d = WB_BOOST;
      end
      WB_BOOST: begin
        if (!mem_valid || mem_xfer) state_d = WB_NORMAL;
      end
      default: state_d = WB_NORMAL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM state register (with the counter that drives it).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= WB_NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Registered write port. Address/data hold when idle; only rf_we drops.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (mem_xfer) win_req = '{rd: mem_rd, data: mem_data};
    else          win_req = '{rd: alu_rd, data: alu_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we      <= 1'b0;
      rf_wr_addr <= RegZero;
      rf_wr_data <= DataZero;
    end else if (alu_xfer || mem_xfer) begin
      rf_we      <= wb_writes_reg(win_req.rd);
      rf_wr_addr <= win_req.rd;
      rf_wr_data <= win_req.data;
    end else begin
      rf_we      <= 1'b0;
    end
  end

`ifdef WB_SCOREBOARD_EN
  // ---------------------------------------------------------------------------
  // Outstanding-load scoreboard; a load retires when its writeback transfers.
  // ---------------------------------------------------------------------------
  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .clr_valid   (mem_xfer),
    .clr_rd      (mem_rd),
    .query_rs1   (query_rs1),
    .query_rs2   (query_rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
  );
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam int W = 1 + RegAddrBits + DataBusBits;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                   alu_valid, alu_ready, mem_valid, mem_ready;
  logic [RegAddrBits-1:0] alu_rd, mem_rd, rf_wr_addr;
  logic [DataBusBits-1:0] alu_data, mem_data, rf_wr_data;
  logic                   rf_we;
  wb_state_t              dbg_state;
`ifdef WB_SCOREBOARD_EN
  logic                   issue_valid, rs1_busy, rs2_busy;
  logic [RegAddrBits-1:0] issue_rd, query_rs1, query_rs2;
`endif

  regfile_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .rf_we      (rf_we),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
`ifdef WB_SCOREBOARD_EN
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .query_rs1  (query_rs1),
    .query_rs2  (query_rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  int                     m_wait;   // consecutive refused memory cycles
  logic [RegAddrBits-1:0] m_addr;   // expected held write address
  logic [DataBusBits-1:0] m_data;   // expected held write data
  logic [NumRegs-1:0]     m_busy;   // expected outstanding loads
  logic                   obs_mem_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait = 0;
    m_addr = RegZero;
    m_data = DataZero;
    m_busy = '0;
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle. Called at posedge+1; drives inputs, checks the
  // combinational readies against the model, pushes the expected write-port
  // value, then crosses the edge and pops/compares it.
  // ---------------------------------------------------------------------------
  task automatic step(input logic av, input logic [RegAddrBits-1:0] ard,
                      input logic [DataBusBits-1:0] adat,
                      input logic mv, input logic [RegAddrBits-1:0] mrd,
                      input logic [DataBusBits-1:0] mdat,
                      input logic iv, input logic [RegAddrBits-1:0] ird,
                      input logic [RegAddrBits-1:0] q1, input logic [RegAddrBits-1:0] q2,
                      output logic ag, output logic mg);
    logic [W-1:0] e;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    mem_valid = mv; mem_rd = mrd; mem_data = mdat;
`ifdef WB_SCOREBOARD_EN
    issue_valid = iv; issue_rd = ird; query_rs1 = q1; query_rs2 = q2;
`endif
    #1;
    // Memory wins if alone or once it has been refused STARVE_LIMIT times.
    mg = mv && (!av || m_wait >= int'(STARVE_LIMIT));
    ag = av && !mg;
    obs_mem_ready = mem_ready;
    check("alu_ready", alu_ready, ag);
    check("mem_ready", mem_ready, mg);
`ifdef WB_SCOREBOARD_EN
    check("rs1_busy", rs1_busy, m_busy[q1]);
    check("rs2_busy", rs2_busy, m_busy[q2]);
`endif
    if (ag) begin m_addr = ard; m_data = adat; end
    else if (mg) begin m_addr = mrd; m_data = mdat; end
    e = {(ag || mg) && (m_addr != 5'd0), m_addr, m_data};
    exp_q.push_back(e);
    m_wait = (mv && !mg) ? m_wait + 1 : 0;
    if (mg) m_busy[mrd] = 1'b0;
    if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rf_we", rf_we, e[W-1]);
    check("rf_wr_addr", rf_wr_addr, e[W-2 -: RegAddrBits]);
    check("rf_wr_data", rf_wr_data, e[DataBusBits-1:0]);
  endtask

  task automatic idle(input logic [RegAddrBits-1:0] q1);
    logic ag, mg;
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, q1, 5'd0, ag, mg);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic ag, mg, pa, pm, iv;
    logic [RegAddrBits-1:0] ard, mrd, ird, q1, q2;
    logic [DataBusBits-1:0] adat, mdat;
    int first_mem;

    model_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h2;
`ifdef WB_SCOREBOARD_EN
    issue_valid = 1'b0; issue_rd = '0; query_rs1 = '0; query_rs2 = '0;
`endif

    // Reset held for two cycles; readies must stay low even with requests.
    repeat (2) begin
      @(posedge clk); #1;
      check("reset_rf_we", rf_we, 1'b0);
      check("reset_rf_wr_addr", rf_wr_addr, 5'd0);
      check("reset_rf_wr_data", rf_wr_data, 32'd0);
      check("reset_alu_ready", alu_ready, 1'b0);
      check("reset_mem_ready", mem_ready, 1'b0);
      check("reset_state", dbg_state, WB_NORMAL);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    reset = 1'b1;
    repeat (3) idle(5'd0);

    // ALU only: rd=5, data=0xA5.
    step(1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, ag, mg);
    idle(5'd0);

    // Both valid continuously: ALU wins 4 cycles, memory the 5th, ALU again.
    first_mem = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, 5'd9, 32'h5555, 1'b0, 5'd0, 5'd0, 5'd0, ag, mg);
      if (obs_mem_ready && first_mem == 0) first_mem = i;
      if (i == 4) check("boost_state", dbg_state, WB_BOOST);
      if (i == 5) check("normal_after_boost", dbg_state, WB_NORMAL);
    end
    check("starve_first_mem_win", first_mem, STARVE_LIMIT + 1);
    idle(5'd0);

    // Memory write to x0 is accepted but never raises rf_we.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 5'd0, 5'd0, ag, mg);
    idle(5'd0);

`ifdef WB_SCOREBOARD_EN
    // Issue x7, then see it busy; retire it, then see it clear.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd7, ag, mg);
    #1 check("sb_x7_busy", rs1_busy, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0, ag, mg);
    #1 check("sb_x7_cleared", rs1_busy, 1'b0);
    // Issue and clear x7 together: set wins.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0, ag, mg);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h78, 1'b1, 5'd7, 5'd7, 5'd0, ag, mg);
    #1 check("sb_set_wins", rs1_busy, 1'b1);
    // x0 is never marked busy.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0, ag, mg);
    #1 check("sb_x0_never_busy", rs1_busy, 1'b0);
    idle(5'd0);
`endif

    // Random traffic with held requests until accepted.
    pa = 1'b0; pm = 1'b0;
    ard = '0; mrd = '0; adat = '0; mdat = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pa && $urandom_range(0, 9) < 6) begin
        pa = 1'b1; ard = 5'($urandom_range(0, 31)); adat = $urandom;
      end
      if (!pm && $urandom_range(0, 9) < 5) begin
        pm = 1'b1; mrd = 5'($urandom_range(0, 7)); mdat = $urandom;
      end
      iv = ($urandom_range(0, 3) == 0);
      ird = 5'($urandom_range(0, 7));
      q1 = 5'($urandom_range(0, 7));
      q2 = 5'($urandom_range(0, 7));
      step(pa, ard, adat, pm, mrd, mdat, iv, ird, q1, q2, ag, mg);
      if (ag) pa = 1'b0;
      if (mg) pm = 1'b0;
    end
    idle(5'd0);

    // Reset mid-operation: drive into BOOST, then assert reset the cycle
    // after an ALU transfer; rf_we must drop without waiting for a clock.
    for (int i = 1; i <= 4; i++)
      step(1'b1, 5'(10 + i), 32'h200 + 32'(i), 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 5'd0, 5'd0, ag, mg);
    check("pre_reset_state", dbg_state, WB_BOOST);
    reset = 1'b0;
    #1;
    check("async_reset_rf_we", rf_we, 1'b0);
    check("async_reset_addr", rf_wr_addr, 5'd0);
    check("async_reset_state", dbg_state, WB_NORMAL);
    check("async_reset_mem_ready", mem_ready, 1'b0);
    @(posedge clk); #1;
    alu_valid = 1'b0; mem_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    idle(5'd0);
    // Memory re-presented after reset must wait again behind the ALU.
    step(1'b1, 5'd6, 32'h66, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 5'd0, 5'd0, ag, mg);
    idle(5'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port between two writeback sources: the ALU pipeline and the variable-latency memory/load unit. It sits between the writeback stage and `register_file`, and arbitrates with ALU priority plus a starvation guard for memory. It registers the winner onto the write port, which `register_file` commits on the following negative edge. An optional scoreboard tracks destination registers with outstanding loads, so hazard logic can stall on them.

## Interface
- `STARVE_LIMIT`, 4: consecutive cycles memory may be denied before it is forced to win; legal range 1–15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `alu_valid` in 1: ALU writeback request.
- `alu_ready` out 1: ALU request granted this cycle (combinational).
- `alu_rd` in `RegAddrBits`: ALU destination register.
- `alu_data` in `DataBusBits`: ALU result.
- `mem_valid` in 1: load writeback request.
- `mem_ready` out 1: load request granted this cycle (combinational).
- `mem_rd` in `RegAddrBits`: load destination register.
- `mem_data` in `DataBusBits`: load data.
- `rf_we` out 1: registered write enable to `register_file`.
- `rf_wr_addr` out `RegAddrBits`: registered write address.
- `rf_wr_data` out `DataBusBits`: registered write data.
- Present only with `WB_SCOREBOARD_EN`:
  - `issue_valid` in 1: a load is issued.
  - `issue_rd` in `RegAddrBits`: destination register of the issued load.
  - `query_rs1` / `query_rs2` in `RegAddrBits`: source registers to check.
  - `rs1_busy` / `rs2_busy` out 1: the queried register has a pending load.

## Operation
- Handshake:
  - A transfer occurs when `valid && ready` at a rising edge.
  - A requester holds `valid`, `rd` and `data` stable until it sees `ready`.
  - At most one of `alu_ready` / `mem_ready` is high in any cycle.
- Priority FSM, states NORMAL and MEM_BOOST:
  - NORMAL: if `alu_valid`, the ALU wins; otherwise memory wins if `mem_valid`.
  - MEM_BOOST: if `mem_valid`, memory wins; otherwise the ALU wins if `alu_valid`.
- Starvation counter (4 bits):
  - Increments each cycle `mem_valid && !mem_ready`.
  - Clears on any memory transfer or when `mem_valid` is low.
  - NORMAL → MEM_BOOST when the counter reaches `STARVE_LIMIT`.
  - MEM_BOOST → NORMAL after one memory transfer, or if `mem_valid` drops.
- Output register:
  - On a transfer, loads `rf_wr_addr` / `rf_wr_data` from the winner.
  - `rf_we` is set to 1 unless the winner's rd equals `RegZero`.
  - A write to x0 is still accepted (ready high) but never asserts `rf_we`.
  - With no transfer, `rf_we` goes to 0; address and data hold their previous values.
- Scoreboard (optional): a 32-bit busy vector.
  - `issue_valid` sets `busy[issue_rd]`.
  - A memory transfer clears `busy[mem_rd]`.
  - If set and clear hit the same register in the same cycle, set wins.
  - `RegZero` is never marked busy.
  - `rsN_busy = busy[query_rsN]` is combinational from registered state; there is no same-cycle bypass.

## Timing
- Reset values:
  - `rf_we`=0, `rf_wr_addr`=`RegZero`, `rf_wr_data`=`DataZero`.
  - FSM in NORMAL, counter 0, busy vector 0.
  - `alu_ready` and `mem_ready` follow their combinational inputs; they are 0 while `reset` is low.
- Latency: a transfer at edge N drives `rf_we` high for cycle N+1, and `register_file` commits at the falling edge inside cycle N+1.
- Throughput: one write per cycle.
- A transfer at N followed by another at N+1 produces back-to-back `rf_we` cycles.
- Reset asserted mid-operation: any pending output write is dropped immediately (asynchronous); requesters must re-present after reset deasserts.
- Memory worst-case wait under continuous ALU traffic is `STARVE_LIMIT`+1 cycles.

## Configuration
- `WB_SCOREBOARD_EN`:
  - Defined: the scoreboard ports and logic are built.
  - Undefined: the scoreboard ports are absent, there are no busy flops, and arbitration behaviour is identical.

## Structure
- `RegAddrBits`, `DataBusBits`, `RegZero` and `DataZero` come from the shared constants header `diagv2_const.vh`.
- Add `WbStateNormal` / `WbStateBoost` encodings to that header.
- Scoreboard is a separate sub-module, `wb_scoreboard`, instantiated under `WB_SCOREBOARD_EN`.

## Test plan
- Reset low for 2 cycles, then release, with no requests → `rf_we`=0 and `rf_wr_addr`=0 throughout.
- ALU only: rd=5, data=0xA5 → `alu_ready`=1 the same cycle; next cycle `rf_we`=1, addr=5, data=0xA5.
- Both valid continuously, `STARVE_LIMIT`=4 → ALU wins 4 cycles, memory wins the 5th, then the ALU again.
- Memory write to rd=0 → `mem_ready`=1, and `rf_we` stays 0.
- Scoreboard:
  - Issue a load to x7 → `rs1_busy`=1 for `query_rs1`=7.
  - Memory transfer with rd=7 → `rs1_busy` reads 0 the cycle after.
  - Issue and clear x7 in the same cycle → x7 remains busy.
- Assert reset in the cycle after a transfer → `rf_we` drops to 0 asynchronously and the FSM returns to NORMAL.
